// File: rtl/adder_accum_stage.sv
`default_nettype none
// ============================================================================
// Module      : adder_accum_stage
// Description : Accumulator and operand driver for an external ripple-carry
//               adder. Holds operands stable for SETTLE_CYCLES, captures the
//               sum/cout, and offers the result on a valid/ready handshake.
//               Optional macro ADDER_ACCUM_SATURATE_EN clamps the accumulator
//               to all ones whenever the captured carry-out is set.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_accum_stage #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 4   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  input  logic             acc_clear,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = 4;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_drive = 2'd1;
  localparam logic [1:0] c_hold  = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_carry;
  logic             r_valid;
  logic             w_busy;

  logic             w_accept;
  logic             w_clear;
  logic             w_capture;
  logic             w_handshake;
  logic [WIDTH-1:0] w_capture_val;

  // Clear takes priority over start when both arrive in IDLE.
  assign w_clear     = (r_state == c_idle) && acc_clear;
  assign w_accept    = (r_state == c_idle) && !acc_clear && start;
  assign w_capture   = (r_state == c_drive) && (r_cnt == c_cnt_zero);
  assign w_handshake = (r_state == c_hold) && r_valid && out_ready;

`ifdef ADDER_ACCUM_SATURATE_EN
  assign w_capture_val = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
  assign w_capture_val = add_sum;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept)    w_state_nxt = c_drive;
      c_drive: if (w_capture)   w_state_nxt = c_hold;
      c_hold:  if (w_handshake) w_state_nxt = c_idle;
      default:                  w_state_nxt = c_idle;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    w_busy = (r_state != c_idle);
  end

  // Datapath: counter, operand registers, accumulator and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= c_cnt_zero;
      r_acc   <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_clear) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
      end else if (w_accept) begin
        r_b   <= op_b;
        r_cin <= cin_in;
        r_cnt <= c_cnt_load;
      end

      if (r_state == c_drive) begin
        if (w_capture) begin
          r_acc   <= w_capture_val;
          r_carry <= add_cout;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - c_cnt_one;
        end
      end

      if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign add_a      = r_acc;
  assign add_b      = r_b;
  assign add_cin    = r_cin;
  assign result     = r_acc;
  assign carry_flag = r_carry;
  assign out_valid  = r_valid;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_adder_accum_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_accum_stage
// Description : Self-checking bench; external adder modelled with a 1-cycle
//               lag, expectations from plain modular arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_accum_stage;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             acc_clear;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  logic [WIDTH:0]   r_lag_sum;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] m_acc;
  logic             m_carry;

  adder_accum_stage #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_b      (op_b),
    .cin_in    (cin_in),
    .acc_clear (acc_clear),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .result    (result),
    .carry_flag(carry_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ripple adder stand-in whose outputs trail its inputs by one clock.
  always @(posedge clk) begin
    r_lag_sum <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  end
  assign add_sum  = r_lag_sum[WIDTH-1:0];
  assign add_cout = r_lag_sum[WIDTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    m_acc   = '0;
    m_carry = 1'b0;
    check("clr_result", result, 0);
    check("clr_carry", carry_flag, 0);
    check("clr_busy", busy, 0);
  endtask

  // One accumulate: stall = HOLD cycles with out_ready low and noisy inputs,
  // early = out_ready raised during DRIVE so the first HOLD cycle completes.
  task automatic do_op(input logic [WIDTH-1:0] b, input logic c, input int stall, input bit early);
    int s;
    logic [WIDTH-1:0] exp_r;
    logic             exp_c;
    logic [WIDTH-1:0] a_prev;
    s      = int'(m_acc) + int'(b) + int'(c);
    exp_c  = (s >= (1 << WIDTH));
    exp_r  = WIDTH'(s % (1 << WIDTH));
`ifdef ADDER_ACCUM_SATURATE_EN
    if (exp_c) exp_r = {WIDTH{1'b1}};
`endif
    a_prev = m_acc;

    start  = 1'b1;
    op_b   = b;
    cin_in = c;
    tick();
    start  = 1'b0;
    op_b   = WIDTH'($urandom);
    cin_in = 1'($urandom);
    check("drv_busy", busy, 1);
    check("drv_add_a", add_a, a_prev);
    check("drv_add_b", add_b, b);
    check("drv_add_cin", add_cin, c);
    check("drv_valid", out_valid, 0);
    if (early) out_ready = 1'b1;

    for (int k = 1; k < SETTLE; k++) begin
      start = 1'($urandom);
      tick();
      check("settle_valid", out_valid, 0);
      check("settle_add_a", add_a, a_prev);
      check("settle_add_b", add_b, b);
    end
    start = 1'b0;

    tick();
    check("cap_valid", out_valid, 1);
    check("cap_result", result, exp_r);
    check("cap_carry", carry_flag, exp_c);
    m_acc   = exp_r;
    m_carry = exp_c;

    if (!early) begin
      for (int k = 0; k < stall; k++) begin
        start     = 1'($urandom);
        acc_clear = 1'($urandom);
        op_b      = WIDTH'($urandom);
        tick();
        check("stall_valid", out_valid, 1);
        check("stall_result", result, exp_r);
        check("stall_carry", carry_flag, exp_c);
        check("stall_busy", busy, 1);
      end
      out_ready = 1'b1;
    end

    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    acc_clear = 1'b0;
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 0);
    check("done_result", result, exp_r);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_acc     = '0;
    m_carry   = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    op_b      = '0;
    cin_in    = 1'b0;
    acc_clear = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single add, then chained accumulate ending in a wrap.
    do_op(4'h3, 1'b0, 0, 1'b0);
    do_clear();
    do_op(4'h5, 1'b0, 0, 1'b0);
    do_op(4'h6, 1'b0, 0, 1'b1);
    do_op(4'h7, 1'b1, 0, 1'b0);
    check("chain_final", result, 4'h3);

    // Backpressure with ignored start/clear pulses.
    do_op(4'h2, 1'b0, 10, 1'b0);

    // Clear beats a simultaneous start.
    do_clear();
    do_op(4'h9, 1'b0, 0, 1'b0);
    start     = 1'b1;
    acc_clear = 1'b1;
    op_b      = 4'h4;
    tick();
    start     = 1'b0;
    acc_clear = 1'b0;
    m_acc     = '0;
    m_carry   = 1'b0;
    check("prio_result", result, 0);
    check("prio_busy", busy, 0);
    tick();
    check("prio_busy2", busy, 0);

    // Reset two cycles into DRIVE discards the operation.
    do_op(4'h6, 1'b0, 0, 1'b0);
    start = 1'b1;
    op_b  = 4'hA;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_acc   = '0;
    m_carry = 1'b0;
    check("mrst_add_a", add_a, 0);
    check("mrst_add_b", add_b, 0);
    check("mrst_carry", carry_flag, 0);
    check("mrst_busy", busy, 0);
    for (int k = 0; k < SETTLE + 2; k++) begin
      tick();
      check("mrst_valid", out_valid, 0);
    end

    // Overflow: saturates or wraps depending on build.
    do_op(4'hE, 1'b0, 0, 1'b0);
    do_op(4'h3, 1'b0, 0, 1'b0);
    check("ovf_carry", carry_flag, 1);

    // Randomised accumulate sequence.
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      do_op(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
